// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: asserts NUM_OUT resets asynchronously, then
// releases them synchronously to clk in order (channel 0 first).
module reset_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               sw_reset,
  output logic [NUM_OUT-1:0] reset_out,
  output logic               done,
  output logic               busy
);

  if (NUM_OUT < 1) begin : g_bad_num_out
    $fatal(1, "reset_sequencer: NUM_OUT must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $fatal(1, "reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $fatal(1, "reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step_cycles
    $fatal(1, "reset_sequencer: STEP_CYCLES must be >= 1");
  end

  localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(NUM_OUT + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] CH_ONE    = NUM_OUT'(1);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [NUM_OUT-1:0]  reset_out_reg;
  logic                done_reg;
  logic                busy_reg;

  // The state register acts as the final synchroniser stage, so only
  // SYNC_STAGES-1 dedicated flops precede it.
  logic [SYNC_STAGES-2:0] sync_reg;
  logic                   sync_out;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= sync_reg << 1;
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-2];

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_reg     <= S_RESET;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      reset_out_reg <= '1;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b1;
    end else if (sw_reset && (state_reg != S_RESET)) begin
      // Software reset beats any counter expiry in the same cycle.
      state_reg     <= S_HOLD;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      reset_out_reg <= '1;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b1;
    end else begin
      case (state_reg)
        S_RESET: begin
          cnt_reg <= '0;
          if (!sync_out) begin
            state_reg <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            reset_out_reg <= reset_out_reg & ~CH_ONE;
            idx_reg       <= IDX_W'(1);
            cnt_reg       <= '0;
            if (NUM_OUT == 1) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= S_RELEASE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_reg == STEP_LAST) begin
            reset_out_reg <= reset_out_reg & ~(CH_ONE << idx_reg);
            idx_reg       <= idx_reg + 1'b1;
            cnt_reg       <= '0;
            if (idx_reg == LAST_IDX) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          reset_out_reg <= '0;
        end
        default: begin
          state_reg <= S_RESET;
        end
      endcase
    end
  end

  assign reset_out = reset_out_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (default and a 1-channel variant)
// checked every cycle against an edge-counting reference model.
module tb_reset_sequencer;

  logic       clk;
  logic       async_reset;
  logic       sw_reset;
  logic [3:0] rst_a;
  logic       done_a, busy_a;
  logic [0:0] rst_b;
  logic       done_b, busy_b;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Model parameters per instance: [0] defaults, [1] NUM_OUT=1/SYNC=3/HOLD=1.
  int num_p [2] = '{4, 1};
  int sync_p[2] = '{2, 3};
  int hold_p[2] = '{16, 1};
  int step_p[2] = '{8, 8};

  // n = edges counted since the last reset event; from_async selects whether
  // the synchroniser latency is part of the release schedule.
  int n[2];
  bit from_async[2];

  reset_sequencer dut_a (
    .clk(clk), .async_reset(async_reset), .sw_reset(sw_reset),
    .reset_out(rst_a), .done(done_a), .busy(busy_a)
  );

  reset_sequencer #(.NUM_OUT(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STEP_CYCLES(8)) dut_b (
    .clk(clk), .async_reset(async_reset), .sw_reset(sw_reset),
    .reset_out(rst_b), .done(done_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int release_base(int i);
    return from_async[i] ? (sync_p[i] + hold_p[i]) : hold_p[i];
  endfunction

  function automatic logic [3:0] exp_rst(int i);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < num_p[i]; k++) begin
      v[k] = (n[i] < release_base(i) + k * step_p[i]);
    end
    return v;
  endfunction

  function automatic logic exp_done(int i);
    return n[i] >= release_base(i) + (num_p[i] - 1) * step_p[i];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(string where);
    check($sformatf("%s/a.reset_out", where), 32'(rst_a), 32'(exp_rst(0)));
    check($sformatf("%s/a.done", where), 32'(done_a), 32'(exp_done(0)));
    check($sformatf("%s/a.busy", where), 32'(busy_a), 32'(!exp_done(0)));
    check($sformatf("%s/b.reset_out", where), 32'(rst_b), 32'(exp_rst(1)));
    check($sformatf("%s/b.done", where), 32'(done_b), 32'(exp_done(1)));
    check($sformatf("%s/b.busy", where), 32'(busy_b), 32'(!exp_done(1)));
  endtask

  task automatic model_async();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0;
      from_async[i] = 1'b1;
    end
  endtask

  // One clock edge: advance the model using the inputs sampled at the edge,
  // then compare 1 time unit later.
  task automatic step(string where);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (async_reset) begin
        n[i] = 0;
        from_async[i] = 1'b1;
      end else if (sw_reset && !(from_async[i] && n[i] < sync_p[i])) begin
        n[i] = 0;
        from_async[i] = 1'b0;
      end else begin
        n[i]++;
      end
    end
    #1;
    check_all(where);
  endtask

  task automatic run(int cycles, string where);
    for (int c = 0; c < cycles; c++) step(where);
  endtask

  task automatic note(string msg);
    txn++;
    $display("txn %0d: %s (n=%0d/%0d)", txn, msg, n[0], n[1]);
  endtask

  // Short async pulse placed between edges (0.3 clk period wide).
  task automatic async_short_pulse(string where);
    #3;
    async_reset = 1'b1;
    model_async();
    #1;
    check_all({where, "/immediate"});
    #2;
    async_reset = 1'b0;
  endtask

  initial begin
    int act, len;
    async_reset = 1'b0;
    sw_reset    = 1'b0;
    model_async();

    #1;
    async_reset = 1'b1;
    #1;
    note("power-on async reset asserted");
    check_all("por");
    run(5, "por_hold");
    async_reset = 1'b0;
    run(48, "por_release");

    note("sw_reset for 3 cycles from DONE");
    sw_reset = 1'b1;
    run(3, "sw_high");
    sw_reset = 1'b0;
    run(44, "sw_release");

    note("sub-cycle async pulse");
    async_short_pulse("short");
    run(46, "short_release");

    note("async re-assert at reset_out=1100");
    async_reset = 1'b1;
    run(2, "mid_hold");
    async_reset = 1'b0;
    run(26, "mid_seq");
    check("mid_seq/a.at_1100", 32'(rst_a), 32'h0000_000c);
    async_reset = 1'b1;
    model_async();
    #1;
    check_all("mid_reassert");
    run(1, "mid_reassert_edge");
    async_reset = 1'b0;
    run(45, "mid_restart");

    note("sw_reset coincident with channel 2 expiry");
    async_reset = 1'b1;
    run(1, "coinc_async");
    async_reset = 1'b0;
    run(33, "coinc_pre");
    sw_reset = 1'b1;
    run(1, "coinc_edge");
    check("coinc/a.ch2_held", 32'(rst_a[2]), 32'h1);
    sw_reset = 1'b0;
    run(45, "coinc_restart");

    note("sw_reset while in RESET is ignored");
    async_reset = 1'b1;
    run(1, "ign_async");
    async_reset = 1'b0;
    sw_reset = 1'b1;
    run(1, "ign_sw");
    sw_reset = 1'b0;
    run(45, "ign_release");

    for (int it = 0; it < 24; it++) begin
      act = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 4));
      case (act)
        0: begin
          len = int'($urandom_range(1, 50));
          note($sformatf("random idle %0d", len));
          run(len, "rnd_idle");
        end
        1: begin
          note($sformatf("random sw pulse %0d", len));
          sw_reset = 1'b1;
          run(len, "rnd_sw");
          sw_reset = 1'b0;
          run(int'($urandom_range(1, 45)), "rnd_sw_after");
        end
        2: begin
          note("random short async pulse");
          async_short_pulse("rnd_short");
          run(int'($urandom_range(1, 45)), "rnd_short_after");
        end
        default: begin
          note($sformatf("random async hold %0d", len));
          async_reset = 1'b1;
          model_async();
          #1;
          check_all("rnd_async_immediate");
          run(len, "rnd_async");
          async_reset = 1'b0;
          run(int'($urandom_range(1, 45)), "rnd_async_after");
        end
      endcase
    end
    run(50, "final_settle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output reset synchroniser.
- Asserts NUM_OUT reset outputs asynchronously.
- Releases them synchronously to clk in a fixed order: first after a minimum hold time, then one channel every STEP_CYCLES.
- Adds a synchronous software reset request and a sequence-complete flag.
- Sits at the top of each clock domain and feeds the resets of downstream blocks in dependency order, channel 0 first.

Parameters:
- NUM_OUT, 4: number of reset outputs; legal values ≥1.
- SYNC_STAGES, 2: flops in the async_reset deassertion synchroniser; legal values ≥2.
- HOLD_CYCLES, 16: clk cycles all outputs stay asserted after the synchronised reset releases; legal values ≥1.
- STEP_CYCLES, 8: clk cycles between release of channel k and channel k+1; legal values ≥1.

Ports:
- clk  input  1  domain clock.
- async_reset  input  1  asynchronous, active-high reset. Any pulse width, including less than one clk period.
- sw_reset  input  1  synchronous, active-high software reset request, sampled on posedge clk.
- reset_out  output  NUM_OUT  active-high resets; bit 0 releases first.
- done  output  1  high when every reset_out bit is deasserted.
- busy  output  1  high while the sequencer is in any state other than DONE.

Behaviour:
- Async assertion:
  - All flops (synchroniser, state, counter, channel index, outputs) are asynchronously set or cleared by async_reset.
  - On async_reset high, with no clock edge required: reset_out = all ones, done = 0, busy = 1, state = RESET.
  - Because assertion is asynchronous, the one-cycle minimum pulse width of the old block no longer applies.
- Synchroniser:
  - SYNC_STAGES-deep chain, async-set to 1, shifting in 0 each posedge.
  - Its output is the only path by which async_reset influences deassertion.
- States: RESET, HOLD, RELEASE, DONE.
  - RESET: exit to HOLD on the posedge where the synchroniser output is low. Counter cleared.
  - HOLD: counter increments each cycle. On the posedge where counter reaches HOLD_CYCLES-1, reset_out[0] is cleared, channel index = 1, counter cleared. Next state:
    - NUM_OUT = 1: go to DONE.
    - Otherwise: go to RELEASE.
  - RELEASE: counter increments. On the posedge where counter reaches STEP_CYCLES-1:
    - Clear reset_out[index], increment index, clear counter.
    - If index was NUM_OUT-1, go to DONE.
  - DONE:
    - done = 1, busy = 0, reset_out = 0.
    - Remains here until async_reset or sw_reset.
- Release timing: edges counted from the first posedge at which async_reset is sampled low.
  - reset_out[k] falls on edge SYNC_STAGES + HOLD_CYCLES + k*STEP_CYCLES.
  - done rises on the same edge as reset_out[NUM_OUT-1] falls.
  - With defaults: edges 18, 26, 34, 42.
- Released channels stay released: a bit, once cleared, is not set again except by a new reset event.
- sw_reset:
  - Sampled high at any posedge in any state other than RESET: reset_out = all ones, done = 0, busy = 1, state = HOLD, counter cleared. All of these take effect at that edge.
  - While held high, the block stays in HOLD with counter cleared.
  - Release timing matches the async path, minus the SYNC_STAGES latency, counted from the first edge sampling sw_reset low.
  - sw_reset is ignored in RESET.
- Simultaneous events:
  - async_reset has priority over everything.
  - sw_reset has priority over counter expiry in the same cycle.
- async_reset mid-sequence (HOLD, RELEASE or DONE) immediately re-asserts every output; the sequence restarts from RESET.
- Counter width: clog2(max(HOLD_CYCLES, STEP_CYCLES)), minimum 1 bit.
- Elaboration: parameters outside their legal ranges stop elaboration with a fatal error.
- All outputs are registered; there is no combinational path from sw_reset to any output.

Test Plan:
- Defaults; async_reset high 5 cycles then low:
  - reset_out = 4'b1111 until edge 18.
  - Then 4'b1110 at edge 18, 4'b1100 at 26, 4'b1000 at 34, 4'b0000 at 42.
  - done rises at edge 42; busy falls at edge 42.
- Defaults; async_reset pulse of 0.3 clk period between edges:
  - reset_out goes to 4'b1111 immediately, without waiting for an edge.
  - Full release sequence follows, with channel 0 falling at edge 18 counted from the next posedge.
- Defaults, in DONE; sw_reset high for 3 cycles:
  - reset_out = 4'b1111 at the first sampled edge.
  - Channel 0 releases 16 edges after the first edge sampling sw_reset low; channel 3 after 40.
- Defaults; async_reset re-asserted when reset_out = 4'b1100:
  - Immediate return to 4'b1111 and done = 0.
  - Full sequence restarts on the next deassertion.
- NUM_OUT=1, SYNC_STAGES=3, HOLD_CYCLES=1:
  - reset_out falls and done rises at edge 4.
  - busy = 0 thereafter.
- Defaults; sw_reset asserted in the same cycle that channel 2's STEP counter expires:
  - Channel 2 stays asserted; all outputs reassert.
  - Sequence restarts in HOLD.
